lb_uart_bridge: RTL and testbench

- Upstream command decoder for the SUMP2 local bus.
- Takes a received UART byte stream and parses fixed-format write/read commands into single-cycle `lb_wr`/`lb_rd` strobes with 32-bit address and data.
- Serializes read responses back to the UART transmitter with a valid/ready handshake.
- Sits between the UART RX/TX byte engines and the capture core's local-bus port, in the `clk_lb` domain.

---
 rtl/lb_bridge_pkg.sv | 28 ++
 rtl/lb_uart_bridge.sv | 189 ++++++++++++++++++
 tb/tb_lb_uart_bridge.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lb_bridge_pkg.sv
// Shared constants, state encoding and byte-select helper for the UART to local-bus bridge.
package lb_bridge_pkg;

    localparam logic [7:0]  OP_WR        = 8'hF0;
    localparam logic [7:0]  OP_RD        = 8'hF1;
    localparam logic [31:0] RD_FAIL_DATA = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_TX
    } state_t;

    // Response bytes go out MSB first: index 0 selects bits 31:24.
    function automatic logic [7:0] resp_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/lb_uart_bridge.sv
// Parses UART write/read command bytes into local-bus strobes and streams
// read responses back to the UART transmitter over a valid/ready handshake.
module lb_uart_bridge
    import lb_bridge_pkg::*;
#(
    parameter int unsigned RD_TIMEOUT  = 255,
    parameter int unsigned GAP_TIMEOUT = 65535
) (
    input  logic        clk_lb,
    input  logic        reset_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        lb_wr,
    output logic        lb_rd,
    output logic [31:0] lb_addr,
    output logic [31:0] lb_wr_d,
    input  logic [31:0] lb_rd_d,
    input  logic        lb_rd_rdy,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam logic [15:0] RD_LAST  = 16'(RD_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [1:0]  idx_reg, idx_next;
    logic        is_rd_reg, is_rd_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wr_d_reg, wr_d_next;
    logic [31:0] resp_reg, resp_next;
    logic [7:0]  tx_byte_reg, tx_byte_next;
    logic        tx_valid_reg, tx_valid_next;
    logic        lb_wr_reg, lb_wr_next;
    logic        lb_rd_reg, lb_rd_next;
    logic        busy_reg, busy_next;
    logic [7:0]  err_cnt_reg, err_cnt_next;
    logic        err_inc;

    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= 2'd0;
            is_rd_reg    <= 1'b0;
            cnt_reg      <= 16'd0;
            addr_reg     <= 32'd0;
            wr_d_reg     <= 32'd0;
            resp_reg     <= 32'd0;
            tx_byte_reg  <= 8'd0;
            tx_valid_reg <= 1'b0;
            lb_wr_reg    <= 1'b0;
            lb_rd_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            err_cnt_reg  <= 8'd0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            is_rd_reg    <= is_rd_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            wr_d_reg     <= wr_d_next;
            resp_reg     <= resp_next;
            tx_byte_reg  <= tx_byte_next;
            tx_valid_reg <= tx_valid_next;
            lb_wr_reg    <= lb_wr_next;
            lb_rd_reg    <= lb_rd_next;
            busy_reg     <= busy_next;
            err_cnt_reg  <= err_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        is_rd_next    = is_rd_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        wr_d_next     = wr_d_reg;
        resp_next     = resp_reg;
        tx_byte_next  = tx_byte_reg;
        tx_valid_next = tx_valid_reg;
        lb_wr_next    = 1'b0;
        lb_rd_next    = 1'b0;
        err_inc       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_byte == OP_WR || rx_byte == OP_RD) begin
                        is_rd_next = (rx_byte == OP_RD);
                        idx_next   = 2'd0;
                        cnt_next   = 16'd0;
                        state_next = ST_ADDR;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            ST_ADDR, ST_DATA: begin
                // One counter serves as the inter-byte gap timer here and the read timer later.
                if (rx_valid) begin
                    cnt_next = 16'd0;
                    idx_next = idx_reg + 2'd1;
                    if (state_reg == ST_ADDR) begin
                        addr_next = {addr_reg[23:0], rx_byte};
                    end else begin
                        wr_d_next = {wr_d_reg[23:0], rx_byte};
                    end
                    if (idx_reg == 2'd3) begin
                        if (state_reg == ST_DATA) begin
                            state_next = ST_WR;
                            lb_wr_next = 1'b1;
                        end else if (is_rd_reg) begin
                            state_next = ST_RD;
                            lb_rd_next = 1'b1;
                        end else begin
                            state_next = ST_DATA;
                        end
                    end
                end else if (cnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                    err_inc    = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_WR: begin
                state_next = ST_IDLE;
            end
            ST_RD: begin
                err_inc    = rx_valid;
                cnt_next   = 16'd0;
                state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                err_inc = rx_valid;
                // Data arriving on the expiry cycle takes priority over the timeout.
                if (lb_rd_rdy) begin
                    resp_next     = lb_rd_d;
                    tx_byte_next  = lb_rd_d[31:24];
                    tx_valid_next = 1'b1;
                    idx_next      = 2'd0;
                    state_next    = ST_TX;
                end else if (cnt_reg == RD_LAST) begin
                    resp_next     = RD_FAIL_DATA;
                    tx_byte_next  = RD_FAIL_DATA[31:24];
                    tx_valid_next = 1'b1;
                    idx_next      = 2'd0;
                    err_inc       = 1'b1;
                    state_next    = ST_TX;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_TX: begin
                err_inc = rx_valid;
                if (tx_valid_reg && tx_ready) begin
                    if (idx_reg == 2'd3) begin
                        tx_valid_next = 1'b0;
                        state_next    = ST_IDLE;
                    end else begin
                        idx_next     = idx_reg + 2'd1;
                        tx_byte_next = resp_byte(resp_reg, idx_reg + 2'd1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        err_cnt_next = (err_inc && err_cnt_reg != 8'hFF) ? err_cnt_reg + 8'd1 : err_cnt_reg;
        busy_next    = (state_next != ST_IDLE);
    end

    assign tx_byte  = tx_byte_reg;
    assign tx_valid = tx_valid_reg;
    assign lb_wr    = lb_wr_reg;
    assign lb_rd    = lb_rd_reg;
    assign lb_addr  = addr_reg;
    assign lb_wr_d  = wr_d_reg;
    assign busy     = busy_reg;
    assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_lb_uart_bridge.sv
// Randomized self-checking bench for lb_uart_bridge against a command-level reference model.
module tb_lb_uart_bridge;
    import lb_bridge_pkg::*;

    localparam int RD_TO  = 8;
    localparam int GAP_TO = 20;

    logic        clk_lb    = 1'b0;
    logic        reset_n   = 1'b0;
    logic [7:0]  rx_byte   = 8'd0;
    logic        rx_valid  = 1'b0;
    logic        tx_ready  = 1'b1;
    logic [31:0] lb_rd_d   = 32'd0;
    logic        lb_rd_rdy = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        lb_wr;
    logic        lb_rd;
    logic [31:0] lb_addr;
    logic [31:0] lb_wr_d;
    logic        busy;
    logic [7:0]  err_cnt;

    lb_uart_bridge #(.RD_TIMEOUT(RD_TO), .GAP_TIMEOUT(GAP_TO)) dut (
        .clk_lb(clk_lb), .reset_n(reset_n),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d),
        .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk_lb = ~clk_lb;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int          exp_err  = 0;
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] exp_wd   = 32'd0;

    // Observed bus/UART activity
    logic [63:0] wr_q[$];
    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];
    int          stab_err   = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_byte  = 8'd0;

    always @(negedge clk_lb) begin
        if (reset_n) begin
            if (lb_wr) wr_q.push_back({lb_addr, lb_wr_d});
            if (lb_rd) rd_q.push_back(lb_addr);
            if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
            if (prev_stall && (!tx_valid || tx_byte !== prev_byte)) stab_err++;
        end
        prev_stall = reset_n && tx_valid && !tx_ready;
        prev_byte  = tx_byte;
    end

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic tick();
        @(posedge clk_lb);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic write_cmd(input logic [31:0] a, input logic [31:0] d, input int gmin, input int gmax);
        int wr0;
        int tx0;
        logic [31:0] a_v;
        logic [31:0] d_v;
        wr0 = wr_q.size();
        tx0 = tx_q.size();
        a_v = a;
        d_v = d;
        send_byte(OP_WR, $urandom_range(gmax, gmin));
        for (int i = 0; i < 4; i++) send_byte(a_v[31-8*i -: 8], $urandom_range(gmax, gmin));
        for (int i = 0; i < 4; i++) send_byte(d_v[31-8*i -: 8], $urandom_range(gmax, gmin));
        exp_addr = a;
        exp_wd   = d;
        n_cmp++;
        if (lb_wr !== 1'b1) begin n_fail++; $display("FAIL wr_latency: lb_wr=%b expected 1", lb_wr); end
        n_cmp++;
        if ({lb_addr, lb_wr_d} !== {exp_addr, exp_wd}) begin
            n_fail++; $display("FAIL wr_fields: addr=%h data=%h expected addr=%h data=%h", lb_addr, lb_wr_d, exp_addr, exp_wd);
        end
        tick();
        n_cmp++;
        if ({lb_wr, busy} !== 2'b00) begin n_fail++; $display("FAIL wr_end: lb_wr=%b busy=%b expected 0 0", lb_wr, busy); end
        n_cmp++;
        if (wr_q.size() != wr0 + 1 || tx_q.size() != tx0) begin
            n_fail++; $display("FAIL wr_count: wr pulses=%0d tx bytes=%0d expected 1 0", wr_q.size() - wr0, tx_q.size() - tx0);
        end else begin
            n_cmp++;
            if (wr_q[$] !== {a, d}) begin n_fail++; $display("FAIL wr_pulse: got %h expected %h", wr_q[$], {a, d}); end
        end
        $display("WR   addr=%h data=%h err_cnt=%0d", a, d, err_cnt);
    endtask

    // delay: cycles after the lb_rd cycle at which lb_rd_rdy pulses (0 = never)
    task automatic read_cmd(input logic [31:0] a, input logic [31:0] d, input int delay,
                            input int stall_idx, input int stall_len, input bit early_rdy, input bit junk_mid);
        int rd0;
        int tx0;
        int stab0;
        int c;
        int post;
        int rem;
        bit seen_done;
        logic [31:0] a_v;
        logic [31:0] exp_resp;
        logic [31:0] got;
        rd0   = rd_q.size();
        tx0   = tx_q.size();
        stab0 = stab_err;
        a_v   = a;
        send_byte(OP_RD, $urandom_range(2, 0));
        for (int i = 0; i < 4; i++) send_byte(a_v[31-8*i -: 8], 0);
        exp_addr = a;
        n_cmp++;
        if (lb_rd !== 1'b1 || lb_addr !== a) begin
            n_fail++; $display("FAIL rd_latency: lb_rd=%b addr=%h expected 1 %h", lb_rd, lb_addr, a);
        end
        if (delay >= 1 && delay <= RD_TO) begin
            exp_resp = d;
        end else begin
            exp_resp = 32'hFFFF_FFFF;
            exp_err  = sat_inc(exp_err);
        end
        if (junk_mid) exp_err = sat_inc(exp_err);
        lb_rd_rdy = early_rdy;
        lb_rd_d   = early_rdy ? ~d : $urandom;
        c = 0; post = 0; rem = stall_len; seen_done = 1'b0;
        tx_ready = 1'b1;
        while (post < 3 && c < 200) begin
            tick();
            c++;
            lb_rd_rdy = (c == delay);
            lb_rd_d   = (c == delay) ? d : $urandom;
            rx_valid  = junk_mid && (c == 2);
            rx_byte   = OP_WR;
            if (tx_q.size() - tx0 >= 4) begin
                if (!seen_done) begin
                    seen_done = 1'b1;
                    n_cmp++;
                    if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle_after_tx: busy=%b expected 0", busy); end
                end
                post++;
            end
            if (tx_valid && (tx_q.size() - tx0) == stall_idx && rem > 0) begin
                tx_ready = 1'b0;
                rem--;
            end else begin
                tx_ready = 1'b1;
            end
        end
        lb_rd_rdy = 1'b0;
        rx_valid  = 1'b0;
        tx_ready  = 1'b1;
        got = 32'd0;
        for (int i = 0; i < 4; i++) if (tx0 + i < tx_q.size()) got = {got[23:0], tx_q[tx0+i]};
        n_cmp++;
        if (c >= 200) begin n_fail++; $display("FAIL rd_timeout: response not finished after %0d cycles, required 4 bytes", c); end
        n_cmp++;
        if (tx_q.size() - tx0 != 4) begin n_fail++; $display("FAIL rd_tx_count: got %0d bytes expected 4", tx_q.size() - tx0); end
        n_cmp++;
        if (got !== exp_resp) begin n_fail++; $display("FAIL rd_resp: got %h expected %h", got, exp_resp); end
        n_cmp++;
        if (rd_q.size() != rd0 + 1) begin n_fail++; $display("FAIL rd_pulses: got %0d expected 1", rd_q.size() - rd0); end
        n_cmp++;
        if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL rd_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
        n_cmp++;
        if (stab_err != stab0) begin n_fail++; $display("FAIL tx_stable: %0d unstable stall cycles expected 0", stab_err - stab0); end
        $display("RD   addr=%h delay=%0d stall=%0d@%0d resp=%h err_cnt=%0d", a, delay, stall_len, stall_idx, got, err_cnt);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({tx_byte, tx_valid, lb_wr, lb_rd, lb_addr, lb_wr_d, busy, err_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: tx=%h v=%b wr=%b rd=%b a=%h d=%h busy=%b err=%0d expected all 0",
                               tx_byte, tx_valid, lb_wr, lb_rd, lb_addr, lb_wr_d, busy, err_cnt);
        end
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_write();
        write_cmd(32'h0000_0004, 32'h1234_5678, 0, 0);
        write_cmd($urandom, $urandom, 0, 3);
    endtask

    task automatic test_read();
        read_cmd(32'h0000_0000, 32'hA5A5_0F0F, 3, 1, 5, 1'b0, 1'b0);
        read_cmd($urandom, $urandom, 2, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        read_cmd($urandom, $urandom, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_rdy_boundary();
        read_cmd($urandom, $urandom, RD_TO, 2, 2, 1'b0, 1'b0);
        read_cmd($urandom, $urandom, RD_TO + 1, 0, 0, 1'b0, 1'b0);
        read_cmd($urandom, $urandom, 1, 3, 1, 1'b0, 1'b0);
    endtask

    task automatic test_junk_gap();
        int wr0;
        int rd0;
        wr0 = wr_q.size();
        rd0 = rd_q.size();
        send_byte(8'h55, 0);
        exp_err = sat_inc(exp_err);
        send_byte(OP_WR, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        exp_addr = {exp_addr[15:0], 16'h0000};
        repeat (GAP_TO - 1) tick();
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_early: busy=%b expected 1", busy); end
        tick();
        exp_err = sat_inc(exp_err);
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_abort: busy=%b expected 0", busy); end
        n_cmp++;
        if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL gap_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
        n_cmp++;
        if (lb_addr !== exp_addr || lb_wr_d !== exp_wd) begin
            n_fail++; $display("FAIL gap_hold: addr=%h data=%h expected %h %h", lb_addr, lb_wr_d, exp_addr, exp_wd);
        end
        n_cmp++;
        if (wr_q.size() != wr0 || rd_q.size() != rd0) begin n_fail++; $display("FAIL gap_strobe: strobes seen, expected none"); end
        $display("GAP  abort err_cnt=%0d addr=%h", err_cnt, lb_addr);
        write_cmd($urandom, $urandom, GAP_TO - 1, GAP_TO - 1);
        read_cmd($urandom, $urandom, 4, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_read();
        int tx0;
        tx0 = tx_q.size();
        send_byte(OP_RD, 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        exp_err = 0; exp_addr = 32'd0; exp_wd = 32'd0;
        n_cmp++;
        if ({tx_valid, lb_rd, busy, err_cnt, lb_addr} !== '0) begin
            n_fail++; $display("FAIL async_reset: v=%b rd=%b busy=%b err=%0d addr=%h expected all 0", tx_valid, lb_rd, busy, err_cnt, lb_addr);
        end
        tick();
        reset_n = 1'b1;
        lb_rd_rdy = 1'b1;
        lb_rd_d   = 32'hDEAD_BEEF;
        tick();
        lb_rd_rdy = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (tx_q.size() != tx0) begin n_fail++; $display("FAIL reset_tx: %0d bytes sent expected 0", tx_q.size() - tx0); end
        n_cmp++;
        if ({tx_byte, tx_valid, lb_wr, lb_rd, lb_addr, lb_wr_d, busy, err_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: tx=%h v=%b busy=%b err=%0d expected all 0", tx_byte, tx_valid, busy, err_cnt);
        end
        $display("RST  during RD_WAIT busy=%b tx_valid=%b", busy, tx_valid);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(1, 0) == 0) begin
                write_cmd($urandom, $urandom, 0, $urandom_range(3, 0));
            end else begin
                read_cmd($urandom, $urandom, $urandom_range(RD_TO + 2, 1), $urandom_range(3, 0),
                         $urandom_range(4, 0), 1'($urandom_range(1, 0)), 1'b0);
            end
        end
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 260; i++) begin
            send_byte(8'($urandom_range(239, 0)), 0);
            exp_err = sat_inc(exp_err);
        end
        n_cmp++;
        if (err_cnt !== 8'(exp_err)) begin n_fail++; $display("FAIL err_saturate: got %0d expected %0d", err_cnt, exp_err); end
        $display("SAT  err_cnt=%0d", err_cnt);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_rdy_boundary();
        test_junk_gap();
        test_reset_mid_read();
        test_back_to_back();
        test_err_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
